// File: rtl/led_status_ctrl_if.sv
// Game event pulses in, per-game status codes and RGB LED drives out.
// Pure wiring bundle; timing is set by led_status_ctrl.
// No flow control: events are single-cycle pulses, outputs are levels.
interface led_status_ctrl_if;
  logic       g1_start;
  logic       g1_pause;
  logic       g1_win;
  logic       g1_lose;
  logic       g2_start;
  logic       g2_pause;
  logic       g2_win;
  logic       g2_lose;
  logic [1:0] game1_state;
  logic [1:0] game2_state;
  logic [2:0] led16;
  logic [2:0] led17;

  modport master (
    output g1_start, g1_pause, g1_win, g1_lose,
    output g2_start, g2_pause, g2_win, g2_lose,
    input  game1_state, game2_state, led16, led17
  );

  modport slave (
    input  g1_start, g1_pause, g1_win, g1_lose,
    input  g2_start, g2_pause, g2_win, g2_lose,
    output game1_state, game2_state, led16, led17
  );
endinterface

// File: rtl/led_status_ctrl.sv
// Two independent game status FSMs driving RGB LEDs from one shared blink timer.
// Status code follows the state register directly; LEDs are registered one cycle later.
// No backpressure: every event pulse is consumed in the cycle it is sampled.
module led_status_ctrl #(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int HOLD_BLINKS = 6
) (
  input logic              clk,
  input logic              rst,
  led_status_ctrl_if.slave bus
);

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW = (HOLD_BLINKS > 0) ? $clog2(HOLD_BLINKS + 1) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_BLINKS - 1);

  typedef enum logic [2:0] {
    IDLE, RUN, PAUSED, WIN_BLINK, WIN, LOSE_BLINK, LOSE
  } state_t;

  state_t          st   [2];
  logic [CW-1:0]   bcnt [2];
  logic [2:0]      led  [2];
  logic [DW-1:0]   div_cnt;
  logic            phase;
  logic            tick;
  logic [1:0]      ev_start;
  logic [1:0]      ev_pause;
  logic [1:0]      ev_win;
  logic [1:0]      ev_lose;

  assign ev_start = {bus.g2_start, bus.g1_start};
  assign ev_pause = {bus.g2_pause, bus.g1_pause};
  assign ev_win   = {bus.g2_win,   bus.g1_win};
  assign ev_lose  = {bus.g2_lose,  bus.g1_lose};
  assign tick     = (div_cnt == DIV_MAX);

  function automatic logic [2:0] colour(input state_t s, input logic ph);
    logic [2:0] c;
    c = 3'b000;
    case (s)
      RUN:        c = 3'b001;
      PAUSED:     c = ph ? 3'b000 : 3'b001;
      WIN_BLINK:  c = ph ? 3'b000 : 3'b010;
      WIN:        c = 3'b010;
      LOSE_BLINK: c = ph ? 3'b000 : 3'b100;
      LOSE:       c = 3'b100;
      default:    c = 3'b000;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] code(input state_t s);
    logic [1:0] c;
    c = 2'b00;
    case (s)
      RUN:             c = 2'b11;
      WIN_BLINK, WIN:  c = 2'b01;
      LOSE_BLINK, LOSE: c = 2'b10;
      default:         c = 2'b00;
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      for (int g = 0; g < 2; g++) begin
        st[g]   <= IDLE;
        bcnt[g] <= '0;
        led[g]  <= 3'b000;
      end
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) phase <= ~phase;

      for (int g = 0; g < 2; g++) begin
        led[g] <= colour(st[g], phase);
        // start beats everything, including the final blink tick
        if (ev_start[g]) begin
          st[g] <= RUN;
        end else begin
          case (st[g])
            RUN: begin
              if (ev_lose[g]) begin
                st[g]   <= LOSE_BLINK;
                bcnt[g] <= '0;
              end else if (ev_win[g]) begin
                st[g]   <= WIN_BLINK;
                bcnt[g] <= '0;
              end else if (ev_pause[g]) begin
                st[g] <= PAUSED;
              end
            end
            PAUSED: begin
              if (ev_pause[g]) st[g] <= RUN;
            end
            WIN_BLINK: begin
              if (tick) begin
                if (bcnt[g] == HOLD_MAX) st[g] <= WIN;
                else                     bcnt[g] <= bcnt[g] + 1'b1;
              end
            end
            LOSE_BLINK: begin
              if (tick) begin
                if (bcnt[g] == HOLD_MAX) st[g] <= LOSE;
                else                     bcnt[g] <= bcnt[g] + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.game1_state = code(st[0]);
  assign bus.game2_state = code(st[1]);
  assign bus.led16       = led[0];
  assign bus.led17       = led[1];

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl; expectations are queued per clock edge and
// checked by an independent monitor one time unit after that edge.
module tb_led_status_ctrl;

  localparam logic [7:0] G1S = 8'h01, G1P = 8'h02, G1W = 8'h04, G1L = 8'h08;
  localparam logic [7:0] G2S = 8'h10, G2W = 8'h40, G2L = 8'h80;
  localparam int K16 = 0, K17 = 1, KS1 = 2, KS2 = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [2:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] ev;
  int         edge_n = 0;
  int         base;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [2:0] act;

  led_status_ctrl_if bus ();

  assign {bus.g2_lose, bus.g2_win, bus.g2_pause, bus.g2_start,
          bus.g1_lose, bus.g1_win, bus.g1_pause, bus.g1_start} = ev;

  led_status_ctrl #(.BLINK_DIV(4), .HOLD_BLINKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic string kname(input int k);
    case (k)
      K16:     return "led16";
      K17:     return "led17";
      KS1:     return "game1_state";
      default: return "game2_state";
    endcase
  endfunction

  // Monitor: compares every queued expectation that targets the edge just taken.
  always @(posedge clk) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edge_n) begin
        case (sb[i].kind)
          K16:     act = bus.led16;
          K17:     act = bus.led17;
          KS1:     act = {1'b0, bus.game1_state};
          default: act = {1'b0, bus.game2_state};
        endcase
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s edge=%0d got=%b want=%b", kname(sb[i].kind),
                   sb[i].cyc - base, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic push_abs(input int c, input int k, input logic [2:0] v);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_at(input int n, input int k, input logic [2:0] v);
    push_abs(base + n, k, v);
  endtask

  // Return at the negedge whose following posedge is relative edge n.
  task automatic go(input int n);
    while (edge_n < base + n - 1) @(negedge clk);
    if (edge_n != base + n - 1) begin
      checks++;
      errors++;
      $display("FAIL schedule edge=%0d got=%0d want=%0d", n, edge_n, base + n - 1);
    end
  endtask

  task automatic pulse(input int n, input logic [7:0] m);
    go(n);
    ev = m;
    @(negedge clk);
    ev = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    ev   = 8'h00;
    base = 3;

    // 1: reset/idle, then game 1 start
    for (int i = 0; i <= 10; i++) begin
      expect_at(i, K16, 3'b000); expect_at(i, K17, 3'b000);
      expect_at(i, KS1, 3'b000); expect_at(i, KS2, 3'b000);
    end
    expect_at(11, KS1, 3'b011); expect_at(11, K16, 3'b000);
    expect_at(12, K16, 3'b001); expect_at(12, K17, 3'b000); expect_at(12, KS2, 3'b000);

    // 2: win blink for three ticks, then steady, later events ignored
    expect_at(13, KS1, 3'b001); expect_at(13, K16, 3'b001);
    for (int j = 14; j <= 16; j++) expect_at(j, K16, 3'b000);
    for (int j = 17; j <= 20; j++) expect_at(j, K16, 3'b010);
    for (int j = 21; j <= 24; j++) expect_at(j, K16, 3'b000);
    for (int j = 25; j <= 31; j++) expect_at(j, K16, 3'b010);
    for (int j = 24; j <= 31; j++) expect_at(j, KS1, 3'b001);

    // 3: game 2 lose beats win in the same cycle
    expect_at(32, KS2, 3'b011); expect_at(33, KS2, 3'b011);
    expect_at(34, KS2, 3'b010); expect_at(44, KS2, 3'b010); expect_at(45, KS2, 3'b010);
    expect_at(33, K17, 3'b001); expect_at(34, K17, 3'b001);
    expect_at(35, K17, 3'b100); expect_at(36, K17, 3'b100);
    for (int j = 37; j <= 40; j++) expect_at(j, K17, 3'b000);
    for (int j = 41; j <= 47; j++) expect_at(j, K17, 3'b100);
    expect_at(35, K16, 3'b010); expect_at(45, KS1, 3'b001);

    // 4: pause blinks indefinitely, lose ignored, second pause resumes
    expect_at(48, KS1, 3'b011); expect_at(49, KS1, 3'b011); expect_at(50, KS1, 3'b000);
    expect_at(49, K16, 3'b001); expect_at(50, K16, 3'b001);
    for (int j = 51; j <= 76; j++)
      expect_at(j, K16, ((((j - 1) / 4) % 2) == 0) ? 3'b001 : 3'b000);
    expect_at(60, KS1, 3'b000); expect_at(61, KS1, 3'b000); expect_at(75, KS1, 3'b000);
    expect_at(76, KS1, 3'b011);
    for (int j = 77; j <= 80; j++) expect_at(j, K16, 3'b001);

    // 5: start on the final lose-blink tick wins; game 2 stays in LOSE
    expect_at(82, KS1, 3'b010); expect_at(83, K16, 3'b100); expect_at(91, KS1, 3'b010);
    expect_at(92, KS1, 3'b011); expect_at(92, K16, 3'b100); expect_at(93, K16, 3'b001);
    expect_at(85, K17, 3'b100); expect_at(92, K17, 3'b100); expect_at(93, K17, 3'b100);
    expect_at(85, KS2, 3'b010); expect_at(93, KS2, 3'b010);

    // 6 (first half): win blink running with phase high when reset arrives
    expect_at(94, KS1, 3'b001); expect_at(100, K16, 3'b010);
    expect_at(101, K16, 3'b000); expect_at(101, K17, 3'b000);
    expect_at(101, KS1, 3'b000); expect_at(101, KS2, 3'b000);

    go(1);
    rst = 1'b0;
    pulse(11, G1S);
    pulse(13, G1W);
    pulse(27, G1W);
    pulse(28, G1L);
    pulse(29, G1P);
    pulse(32, G2S);
    pulse(34, G2W | G2L);
    pulse(48, G1S);
    pulse(50, G1P);
    pulse(60, G1L);
    pulse(76, G1P);
    pulse(82, G1L);
    pulse(92, G1S);
    pulse(94, G1W);
    go(101);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    base = base + 101;

    // 6 (second half): win ignored in IDLE; blink phase restarts from zero
    expect_at(1, KS1, 3'b000); expect_at(2, K16, 3'b000);
    expect_at(1, K17, 3'b000); expect_at(1, KS2, 3'b000);
    expect_at(2, KS1, 3'b011); expect_at(3, KS1, 3'b000);
    expect_at(3, K16, 3'b001); expect_at(4, K16, 3'b001);
    for (int j = 5; j <= 8; j++) expect_at(j, K16, 3'b000);
    for (int j = 9; j <= 12; j++) expect_at(j, K16, 3'b001);
    expect_at(13, K16, 3'b000);

    pulse(1, G1W);
    pulse(2, G1S);
    pulse(3, G1P);
    go(16);

    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL unchecked %s edge=%0d got=none want=%b", kname(sb[0].kind),
               sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
